// File: rtl/present_dec_serial_pkg.sv
// Shared PRESENT-80 definitions: widths, round bounds, FSM states and the
// S-box / permutation / forward key schedule helpers.
package present_dec_serial_pkg;

    localparam int unsigned c_DataWidth  = 64;
    localparam int unsigned c_KeyWidth   = 80;
    localparam int unsigned c_RoundWidth = 5;

    localparam logic [c_RoundWidth-1:0] c_FirstRound = 5'd1;
    localparam logic [c_RoundWidth-1:0] c_LastRound  = 5'd31;

    typedef enum logic [1:0] {
        s_Idle    = 2'd0,
        s_KeyExp  = 2'd1,
        s_Decrypt = 2'd2
    } state_t;

    function automatic logic [3:0] sBox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] invSBox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    // Forward pLayer moves bit i to 16*i mod 63, so the inverse gathers from there.
    function automatic logic [c_DataWidth-1:0] invPLayer(input logic [c_DataWidth-1:0] d);
        logic [c_DataWidth-1:0] r;
        r[63] = d[63];
        for (int i = 0; i < 63; i++) begin
            r[i] = d[6'((16 * i) % 63)];
        end
        return r;
    endfunction

    function automatic logic [c_DataWidth-1:0] invSLayer(input logic [c_DataWidth-1:0] d);
        logic [c_DataWidth-1:0] r;
        for (int n = 0; n < 16; n++) begin
            r[4*n +: 4] = invSBox(d[4*n +: 4]);
        end
        return r;
    endfunction

    function automatic logic [c_KeyWidth-1:0] fwdKeyUpdate(input logic [c_KeyWidth-1:0]   k,
                                                            input logic [c_RoundWidth-1:0] rc);
        logic [c_KeyWidth-1:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sBox(t[79:76]);
        t[19:15]   = t[19:15] ^ rc;
        return t;
    endfunction

endpackage

// File: rtl/present_dec_serial_key_update_inv.sv
// Combinational inverse PRESENT-80 key schedule step: undoes one forward update.
module present_dec_serial_key_update_inv
    import present_dec_serial_pkg::*;
(
    input  logic [c_KeyWidth-1:0]   Data_ib,
    input  logic [c_RoundWidth-1:0] RoundCount_ib,
    output logic [c_KeyWidth-1:0]   Data_ob
);

    logic [c_KeyWidth-1:0] mixed;

    // Undo constant XOR and S-box before rotating back right by 61.
    always_comb begin
        mixed          = Data_ib;
        mixed[19:15]   = Data_ib[19:15] ^ RoundCount_ib;
        mixed[79:76]   = invSBox(Data_ib[79:76]);
        Data_ob        = {mixed[60:0], mixed[79:61]};
    end

endmodule

// File: rtl/present_dec_serial.sv
// Round-serial PRESENT-80 decryption core: forward key expansion to the
// round-32 key, then 31 inverse rounds at one per clock.
module present_dec_serial
    import present_dec_serial_pkg::*;
#(
    parameter bit g_SkipKeyExpansion = 1'b0
)
(
    input  logic                   Clk_ik,
    input  logic                   Reset_irn,
    input  logic [c_DataWidth-1:0] CipherText_ib,
    input  logic [c_KeyWidth-1:0]  Key_ib,
    output logic [c_DataWidth-1:0] PlainText_ob,
    input  logic                   Start_i,
    output logic                   Ready_o,
    output logic                   Done_o,
    input  logic [7:0]             TextRegEnable_ib,
    input  logic [9:0]             KeyRegEnable_ib
);

    state_t                  state, stateNext;
    logic [c_DataWidth-1:0]  dataReg, dataNext;
    logic [c_KeyWidth-1:0]   keyReg, keyNext, keyInv;
    logic [c_RoundWidth-1:0] round, roundNext;
    logic                    readyNext, doneNext;

    present_dec_serial_key_update_inv i_keyUpdateInv (
        .Data_ib       (keyReg),
        .RoundCount_ib (round),
        .Data_ob       (keyInv)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        stateNext = state;
        dataNext  = dataReg;
        keyNext   = keyReg;
        roundNext = round;
        doneNext  = 1'b0;
        case (state)
            s_Idle: begin
                if (Start_i) begin
                    if (g_SkipKeyExpansion) begin
                        stateNext = s_Decrypt;
                        roundNext = c_LastRound;
                    end else begin
                        stateNext = s_KeyExp;
                        roundNext = c_FirstRound;
                    end
                end else begin
                    for (int i = 0; i < 8; i++) begin
                        if (TextRegEnable_ib[i]) dataNext[8*i +: 8] = CipherText_ib[8*i +: 8];
                    end
                    for (int i = 0; i < 10; i++) begin
                        if (KeyRegEnable_ib[i]) keyNext[8*i +: 8] = Key_ib[8*i +: 8];
                    end
                end
            end
            s_KeyExp: begin
                keyNext = fwdKeyUpdate(keyReg, round);
                if (round == c_LastRound) begin
                    stateNext = s_Decrypt;
                end else begin
                    roundNext = round + 5'd1;
                end
            end
            s_Decrypt: begin
                dataNext = invSLayer(invPLayer(dataReg ^ keyReg[79:16]));
                keyNext  = keyInv;
                if (round == c_FirstRound) begin
                    stateNext = s_Idle;
                    roundNext = '0;
                    doneNext  = 1'b1;
                end else begin
                    roundNext = round - 5'd1;
                end
            end
            default: begin
                stateNext = s_Idle;
                roundNext = '0;
            end
        endcase
        readyNext = (stateNext == s_Idle);
    end

    always_ff @(posedge Clk_ik or negedge Reset_irn) begin
        if (!Reset_irn) begin
            state        <= s_Idle;
            dataReg      <= '0;
            keyReg       <= '0;
            round        <= '0;
            Ready_o      <= 1'b1;
            Done_o       <= 1'b0;
            PlainText_ob <= '0;
        end else begin
            state        <= stateNext;
            dataReg      <= dataNext;
            keyReg       <= keyNext;
            round        <= roundNext;
            Ready_o      <= readyNext;
            Done_o       <= doneNext;
            PlainText_ob <= dataNext ^ keyNext[79:16];
        end
    end

endmodule

// File: tb/tb_present_dec_serial.sv
// Randomised self-checking bench for present_dec_serial against a
// transaction-level PRESENT-80 reference model.
module tb_present_dec_serial;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] ct    = '0;
    logic [79:0] key   = '0;
    logic        start = 1'b0;
    logic [7:0]  textEn = '0;
    logic [9:0]  keyEn  = '0;
    logic [63:0] pt;
    logic        ready, done;

    logic        sStart  = 1'b0;
    logic [7:0]  sTextEn = '0;
    logic [9:0]  sKeyEn  = '0;
    logic [63:0] sPt;
    logic        sReady, sDone;

    int   nChecks = 0;
    int   nPass   = 0;
    logic checkOn = 1'b0;
    logic noise   = 1'b0;

    always #5 clk = ~clk;

    present_dec_serial #(.g_SkipKeyExpansion(1'b0)) dut (
        .Clk_ik(clk), .Reset_irn(rst_n), .CipherText_ib(ct), .Key_ib(key),
        .PlainText_ob(pt), .Start_i(start), .Ready_o(ready), .Done_o(done),
        .TextRegEnable_ib(textEn), .KeyRegEnable_ib(keyEn)
    );

    present_dec_serial #(.g_SkipKeyExpansion(1'b1)) dutSkip (
        .Clk_ik(clk), .Reset_irn(rst_n), .CipherText_ib(ct), .Key_ib(key),
        .PlainText_ob(sPt), .Start_i(sStart), .Ready_o(sReady), .Done_o(sDone),
        .TextRegEnable_ib(sTextEn), .KeyRegEnable_ib(sKeyEn)
    );

    localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    function automatic int pIdx(input int i);
        return (i == 63) ? 63 : (16 * i) % 63;
    endfunction

    function automatic logic [3:0] invS(input logic [3:0] x);
        logic [3:0] r = 4'h0;
        for (int y = 0; y < 16; y++) if (SB[y] == x) r = 4'(y);
        return r;
    endfunction

    function automatic logic [79:0] keyStep(input logic [79:0] k, input int r);
        logic [79:0] t;
        t = {k[18:0], k[79:19]};
        t[79:76] = SB[t[79:76]];
        t[19:15] = t[19:15] ^ 5'(r);
        return t;
    endfunction

    function automatic logic [63:0] encryptRef(input logic [63:0] p, input logic [79:0] k);
        logic [79:0] kk;
        logic [63:0] s, t;
        kk = k;
        s  = p;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ kk[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
            for (int i = 0; i < 64; i++) t[pIdx(i)] = s[i];
            s  = t;
            kk = keyStep(kk, r);
        end
        return s ^ kk[79:16];
    endfunction

    function automatic logic [63:0] decryptRef(input logic [63:0] c, input logic [79:0] k);
        logic [79:0] rk [1:32];
        logic [63:0] s, t;
        rk[1] = k;
        for (int r = 1; r <= 31; r++) rk[r+1] = keyStep(rk[r], r);
        s = c ^ rk[32][79:16];
        for (int r = 31; r >= 1; r--) begin
            for (int i = 0; i < 64; i++) t[i] = s[pIdx(i)];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = invS(t[4*n +: 4]);
            s = s ^ rk[r][79:16];
        end
        return s;
    endfunction

    function automatic logic [63:0] mergeText(input logic [63:0] old, input logic [63:0] d,
                                              input logic [7:0] en);
        logic [63:0] r = old;
        for (int i = 0; i < 8; i++) if (en[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [79:0] mergeKey(input logic [79:0] old, input logic [79:0] d,
                                             input logic [9:0] en);
        logic [79:0] r = old;
        for (int i = 0; i < 10; i++) if (en[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Reference: idle registers, run counter, and the ciphertext captured at start.
    logic [63:0] mData, runCt, expPt;
    logic [79:0] mKey;
    int          busyLeft;
    logic        expReady, expDone;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mData <= '0; mKey <= '0; runCt <= '0;
            busyLeft <= 0; expReady <= 1'b1; expDone <= 1'b0;
        end else if (busyLeft > 1) begin
            busyLeft <= busyLeft - 1;
            expDone  <= 1'b0;
        end else if (busyLeft == 1) begin
            busyLeft <= 0;
            mData    <= decryptRef(runCt, mKey) ^ mKey[79:16];
            expReady <= 1'b1;
            expDone  <= 1'b1;
        end else if (start) begin
            runCt    <= mData;
            busyLeft <= 62;
            expReady <= 1'b0;
            expDone  <= 1'b0;
        end else begin
            mData   <= mergeText(mData, ct, textEn);
            mKey    <= mergeKey(mKey, key, keyEn);
            expDone <= 1'b0;
        end
    end

    assign expPt = mData ^ mKey[79:16];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (checkOn && rst_n) begin
            check("cyc_ready", 80'(ready), 80'(expReady));
            check("cyc_done",  80'(done),  80'(expDone));
            if (expReady) check("cyc_pt", 80'(pt), 80'(expPt));
        end
    end

    task automatic loadAll(input logic [63:0] c, input logic [79:0] k);
        ct = c; key = k; textEn = '1; keyEn = '1;
        @(posedge clk); #1;
        textEn = '0; keyEn = '0;
    endtask

    // One byte enable per cycle in shuffled order; key bytes optional.
    task automatic loadBytes(input logic [63:0] c, input logic [79:0] k, input bit withKey);
        int ord [18];
        int tmp, j;
        for (int i = 0; i < 18; i++) ord[i] = i;
        for (int i = 17; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
        end
        ct = c; key = k;
        for (int i = 0; i < 18; i++) begin
            if (ord[i] < 10) begin
                if (withKey) begin
                    keyEn = 10'(1) << ord[i];
                    @(posedge clk); #1;
                end
            end else begin
                textEn = 8'(1) << (ord[i] - 10);
                @(posedge clk); #1;
            end
            textEn = '0; keyEn = '0;
        end
    endtask

    task automatic runWait(input int expCyc, input string name);
        int cyc = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; textEn = '0; keyEn = '0;
        while (!done && cyc < 200) begin
            if (noise) begin
                start  = 1'($urandom);
                textEn = 8'($urandom);
                keyEn  = 10'($urandom);
                ct     = {$urandom, $urandom};
                key    = {16'($urandom), $urandom, $urandom};
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; textEn = '0; keyEn = '0;
        check({name, "_latency"}, 80'(cyc), 80'(expCyc));
    endtask

    initial begin
        logic [63:0] c;
        logic [79:0] k, curKey, k32;
        int          cyc;

        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", 80'(ready), 80'(1));
        check("rst_done",  80'(done),  80'(0));
        check("rst_pt",    80'(pt),    80'(0));
        check("rst_skip_ready", 80'(sReady), 80'(1));

        // Pin the reference model to published PRESENT-80 vectors.
        check("ref_enc_00", 80'(encryptRef(64'h0, 80'h0)), 80'h5579C1387B228445);
        check("ref_enc_F0", 80'(encryptRef('1, 80'h0)),    80'hA112FFC72F68417B);
        check("ref_dec_0F", 80'(decryptRef(64'hE72C46C0F5945049, '1)), 80'h0);
        check("ref_dec_FF", 80'(decryptRef(64'h3333DCD3213210D2, '1)), 80'hFFFFFFFFFFFFFFFF);

        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checkOn = 1'b1;

        loadAll(64'h5579C1387B228445, 80'h0);
        runWait(62, "vec1");
        check("vec1_pt", 80'(pt), 80'h0);

        loadBytes(64'hE72C46C0F5945049, '1, 1'b1);
        runWait(62, "vec2");
        check("vec2_pt", 80'(pt), 80'h0);

        loadAll(64'hA112FFC72F68417B, 80'h0);
        runWait(62, "vec3");
        check("vec3_pt", 80'(pt), 80'hFFFFFFFFFFFFFFFF);
        loadBytes(64'h5579C1387B228445, 80'h0, 1'b0);
        runWait(62, "reuse0");
        check("reuse0_pt", 80'(pt), 80'h0);

        loadAll(64'h3333DCD3213210D2, '1);
        noise = 1'b1;
        runWait(62, "vec4noise");
        noise = 1'b0;
        check("vec4_pt", 80'(pt), 80'hFFFFFFFFFFFFFFFF);
        loadBytes(64'hE72C46C0F5945049, 80'h0, 1'b0);
        runWait(62, "reuse1");
        check("reuse1_pt", 80'(pt), 80'h0);

        // Start together with enables: enables must be ignored.
        c = {$urandom, $urandom};
        k = {16'($urandom), $urandom, $urandom};
        loadAll(c, k);
        ct = ~c; key = ~k; textEn = '1; keyEn = '1;
        runWait(62, "startwins");
        check("startwins_pt", 80'(pt), 80'(decryptRef(c, k)));

        // Abort mid-run with reset.
        loadAll({$urandom, $urandom}, {16'($urandom), $urandom, $urandom});
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", 80'(ready), 80'(1));
        check("abort_pt",    80'(pt),    80'(0));
        check("abort_done",  80'(done),  80'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        loadAll(64'hA112FFC72F68417B, 80'h0);
        runWait(62, "fresh");
        check("fresh_pt", 80'(pt), 80'hFFFFFFFFFFFFFFFF);
        curKey = 80'h0;

        for (int r = 0; r < 8; r++) begin
            bit newKey;
            newKey = (r == 0) || ($urandom_range(0, 1) == 1);
            c = {$urandom, $urandom};
            if (newKey) curKey = {16'($urandom), $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) loadBytes(c, curKey, newKey);
            else if (newKey) loadAll(c, curKey);
            else loadBytes(c, curKey, 1'b0);
            noise = 1'($urandom);
            runWait(62, "rand");
            noise = 1'b0;
            check("rand_pt", 80'(pt), 80'(decryptRef(c, curKey)));
        end

        // Pre-expanded key variant.
        k32 = 80'h0;
        for (int r = 1; r <= 31; r++) k32 = keyStep(k32, r);
        ct = 64'h5579C1387B228445; key = k32; sTextEn = '1; sKeyEn = '1;
        @(posedge clk); #1;
        sTextEn = '0; sKeyEn = '0;
        sStart = 1'b1;
        @(posedge clk); #1;
        sStart = 1'b0;
        check("skip_busy", 80'(sReady), 80'(0));
        cyc = 0;
        while (!sDone && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("skip_latency", 80'(cyc),    80'(31));
        check("skip_ready",   80'(sReady), 80'(1));
        check("skip_pt",      80'(sPt),    80'h0);

        @(posedge clk); #1;
        checkOn = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
